// File: rtl/serial_sorter8.sv
// Sequential odd-even transposition sorter sharing one twoSorter8 element.
// Optional macro SERIAL_SORTER_EARLY_EXIT_EN ends SORT after two clean phases.
module twoSorter8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] lower,
    output logic [7:0] higher,
    output logic       swap
);
    assign swap   = (y < x);
    assign lower  = swap ? y : x;
    assign higher = swap ? x : y;
endmodule

module serial_sorter8 #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy
);
    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST     = W'(N - 1);
    localparam logic [W-1:0] EVEN_END = W'(N - 2);
    localparam logic [W-1:0] ODD_END  = W'(N - 3);
    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] TWO      = W'(2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t     state, state_nx;
    logic [7:0] mem [N];
    logic [W-1:0] wr_idx, rd_idx, pi, pi1, ph;
    logic [7:0] lo, hi;
    logic       swap;
    logic       ph_end, early, sort_done;

    assign pi1 = pi + ONE;

    twoSorter8 u_cmp (
        .x      (mem[pi]),
        .y      (mem[pi1]),
        .lower  (lo),
        .higher (hi),
        .swap   (swap)
    );

    assign ph_end = ph[0] ? (pi == ODD_END) : (pi == EVEN_END);

`ifdef SERIAL_SORTER_EARLY_EXIT_EN
    logic swapped, prev_clean, cur_dirty;

    assign cur_dirty = swapped | swap;
    assign early     = ph_end & prev_clean & ~cur_dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swapped    <= 1'b0;
            prev_clean <= 1'b0;
        end else if (state == SORT) begin
            if (sort_done) begin
                swapped    <= 1'b0;
                prev_clean <= 1'b0;
            end else if (ph_end) begin
                swapped    <= 1'b0;
                prev_clean <= ~cur_dirty;
            end else begin
                swapped <= cur_dirty;
            end
        end
    end
`else
    assign early = 1'b0;
`endif

    // N=2 has an empty odd phase, so the first even phase is the last one.
    assign sort_done = ph_end & ((ph == LAST) | (N == 2) | early);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  if (in_valid && wr_idx == LAST) state_nx = SORT;
            SORT:  if (sort_done) state_nx = DRAIN;
            DRAIN: if (out_ready && rd_idx == LAST) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) mem[k] <= 8'd0;
            wr_idx <= '0;
            rd_idx <= '0;
            pi     <= '0;
            ph     <= '0;
        end else begin
            unique case (state)
                LOAD: if (in_valid) begin
                    mem[wr_idx] <= in_data;
                    wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + ONE;
                    rd_idx <= '0;
                    pi     <= '0;
                    ph     <= '0;
                end
                SORT: begin
                    if (swap) begin
                        mem[pi]  <= lo;
                        mem[pi1] <= hi;
                    end
                    if (sort_done) begin
                        pi <= '0;
                        ph <= '0;
                    end else if (ph_end) begin
                        pi <= ph[0] ? '0 : ONE;
                        ph <= ph + ONE;
                    end else begin
                        pi <= pi + TWO;
                    end
                end
                DRAIN: if (out_ready)
                    rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + ONE;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != LOAD);
    assign out_data  = out_valid ? mem[rd_idx] : 8'd0;
    assign out_last  = out_valid & (rd_idx == LAST);
endmodule

// File: tb/tb_serial_sorter8.sv
// Directed bench for serial_sorter8: sort results, timing, stalls, reset.
module tb_serial_sorter8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] din  [8];
    logic [7:0] dexp [8];

    serial_sorter8 #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_block();
        for (int k = 0; k < 8; k++) begin
            chk("in_ready_load", in_ready, 1);
            chk("busy_load", busy, 0);
            in_valid = 1'b1;
            in_data  = din[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic run_sort(input int exp_cyc, input bit hold);
        int n = 0;
        while (!out_valid && n < 100) begin
            chk("busy_sort", busy, 1);
            chk("in_ready_sort", in_ready, 0);
            if (hold) begin
                in_valid = 1'b1;
                in_data  = 8'hAA;
            end
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
        if (exp_cyc >= 0) chk("sort_cycles", n, exp_cyc);
        else              chk("sort_done", out_valid, 1);
    endtask

    task automatic drain(input bit toggle);
        int  k = 0;
        int  cyc = 0;
        bit  rdy = !toggle;
        while (k < 8 && cyc < 100) begin
            out_ready = rdy;
            chk("out_valid", out_valid, 1);
            chk("busy_drain", busy, 1);
            chk($sformatf("out_data[%0d]", k), out_data, dexp[k]);
            chk("out_last", out_last, (k == 7) ? 1 : 0);
            if (rdy) k++;
            if (toggle) rdy = !rdy;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_beats", k, 8);
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        din  = '{8'd17, 8'd3, 8'd4, 8'd6, 8'd200, 8'd0, 8'd255, 8'd4};
        dexp = '{8'd0, 8'd3, 8'd4, 8'd4, 8'd6, 8'd17, 8'd200, 8'd255};
        load_block();
`ifdef SERIAL_SORTER_EARLY_EXIT_EN
        run_sort(-1, 1'b0);
`else
        run_sort(28, 1'b0);
`endif
        drain(1'b0);

        din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block();
        run_sort(28, 1'b0);
        drain(1'b0);

        din  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block();
`ifdef SERIAL_SORTER_EARLY_EXIT_EN
        run_sort(7, 1'b0);
`else
        run_sort(28, 1'b0);
`endif
        drain(1'b0);

        din  = '{8'd9, 8'd9, 8'd0, 8'd0, 8'd255, 8'd255, 8'd1, 8'd1};
        dexp = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd9, 8'd9, 8'd255, 8'd255};
        load_block();
        run_sort(-1, 1'b0);
        drain(1'b1);

        din  = '{8'd17, 8'd3, 8'd4, 8'd6, 8'd200, 8'd0, 8'd255, 8'd4};
        dexp = '{8'd0, 8'd3, 8'd4, 8'd4, 8'd6, 8'd17, 8'd200, 8'd255};
        load_block();
        run_sort(-1, 1'b1);
        drain(1'b0);

        din  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        dexp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_block();
        run_sort(-1, 1'b0);
        drain(1'b0);

        din = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1};
        load_block();
        repeat (10) @(negedge clk);
        chk("mid_sort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        din  = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd7, 8'd6};
        dexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        load_block();
        run_sort(-1, 1'b0);
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
